// File: rtl/if_fetch_stage.sv
// if_fetch_stage: IF-stage PC register and instruction-fetch controller.
// Keeps at most one request in flight to a variable-latency instruction memory.
// Delivers each fetched word and its PC into the IF/ID register.
// Handles stall, flush and redirect while a request is outstanding.
// Optional macro FETCH_PERF_CNT_EN adds the FetchCnt/DropCnt performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PC_In,
  input  logic        Redirect,
  input  logic        StallF,
  input  logic        FlushD,
  output logic [31:0] PCF,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic        ValidD,
  output logic        FetchBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] DropCnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic        drop_resp;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
`endif

  // Fetch FSM: next state, hold-buffer capture, deliver/discard events and next PC
  always_comb begin
    state_d       = state_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = ImemRespData;
    deliver_pc    = pcf_q;
    drop_resp     = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (ImemReqReady) begin
          state_d = Redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (ImemRespValid) begin
          if (Redirect) begin
            drop_resp = 1'b1;
            state_d   = S_REQ;
          end else if (StallF) begin
            hold_instr_d = ImemRespData;
            hold_pc_d    = pcf_q;
            state_d      = S_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = S_REQ;
          end
        end else if (Redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (ImemRespValid) begin
          drop_resp = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          state_d = S_REQ;
        end else if (!StallF) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    pcf_d = (deliver || Redirect) ? PC_In : pcf_q;
  end

  // IF/ID register update: flush beats stall, stall beats deliver, otherwise bubble
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    if (FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (StallF) begin
      valid_d = valid_q;
    end else if (deliver) begin
      valid_d = 1'b1;
      instr_d = deliver_instr;
      pcd_d   = deliver_pc;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: delivered instructions and discarded responses
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, deliver};
    drop_cnt_d  = drop_cnt_q + {31'd0, drop_resp};
  end
`endif

  // State registers with asynchronous reset
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q      <= S_REQ;
      pcf_q        <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcd_q        <= 32'd0;
      valid_q      <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= 32'd0;
      drop_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= fetch_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign PCF          = pcf_q;
  assign ImemReqValid = (state_q == S_REQ);
  assign ImemReqAddr  = pcf_q;
  assign InstrD       = instr_q;
  assign PCD          = pcd_q;
  assign ValidD       = valid_q;
  assign FetchBusy    = !deliver;
`ifdef FETCH_PERF_CNT_EN
  assign FetchCnt     = fetch_cnt_q;
  assign DropCnt      = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized bench for if_fetch_stage.
// Contains a transaction-level model of the fetch unit and a variable-latency memory.
// The model tracks outstanding requests as a queue with a stale flag, plus a hold queue.
// Counters are checked only when FETCH_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic [31:0] PC_In;
  logic        Redirect, StallF, FlushD;
  logic [31:0] PCF;
  logic        ImemReqValid;
  logic [31:0] ImemReqAddr;
  logic        ImemReqReady, ImemRespValid;
  logic [31:0] ImemRespData;
  logic [31:0] InstrD, PCD;
  logic        ValidD, FetchBusy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt, DropCnt;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PC_In(PC_In), .Redirect(Redirect),
    .StallF(StallF), .FlushD(FlushD), .PCF(PCF), .ImemReqValid(ImemReqValid),
    .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .FetchBusy(FetchBusy)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .DropCnt(DropCnt)
`endif
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 CPU_CLK = ~CPU_CLK;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // architectural model state
  logic [31:0] m_pcf, m_instr, m_pcd;
  logic        m_valid;
  logic [31:0] oq_addr[$];
  bit          oq_stale[$];
  logic [31:0] hq_instr[$];
  logic [31:0] hq_pc[$];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_fetch_cnt, m_drop_cnt;
`endif

  // events decided for the current cycle
  bit          e_req_valid, e_deliver, e_pop, e_discard, e_to_hold, e_hold_pop, e_accept, e_mark_stale;
  logic [31:0] e_d_instr, e_d_pc;

  // memory model
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcf   = RESET_PC;
    m_instr = NOP;
    m_pcd   = 32'd0;
    m_valid = 1'b0;
    oq_addr.delete();
    oq_stale.delete();
    hq_instr.delete();
    hq_pc.delete();
`ifdef FETCH_PERF_CNT_EN
    m_fetch_cnt = 32'd0;
    m_drop_cnt  = 32'd0;
`endif
    mem_busy = 1'b0;
    mem_wait = 0;
    e_req_valid = 1'b1;
    e_deliver   = 1'b0;
  endtask

  // decide what happens this cycle from the model state and the applied inputs
  task automatic model_eval();
    e_req_valid  = (oq_addr.size() == 0) && (hq_instr.size() == 0);
    e_deliver    = 1'b0;
    e_pop        = 1'b0;
    e_discard    = 1'b0;
    e_to_hold    = 1'b0;
    e_hold_pop   = 1'b0;
    e_accept     = 1'b0;
    e_mark_stale = 1'b0;
    e_d_instr    = 32'd0;
    e_d_pc       = 32'd0;
    if (oq_addr.size() != 0 && ImemRespValid) begin
      e_pop = 1'b1;
      if (oq_stale[0] || Redirect) e_discard = 1'b1;
      else if (StallF) e_to_hold = 1'b1;
      else begin
        e_deliver = 1'b1;
        e_d_instr = ImemRespData;
        e_d_pc    = oq_addr[0];
      end
    end else if (oq_addr.size() != 0 && Redirect) begin
      e_mark_stale = 1'b1;
    end
    if (hq_instr.size() != 0) begin
      if (Redirect) e_hold_pop = 1'b1;
      else if (!StallF) begin
        e_hold_pop = 1'b1;
        e_deliver  = 1'b1;
        e_d_instr  = hq_instr[0];
        e_d_pc     = hq_pc[0];
      end
    end
    e_accept = e_req_valid && ImemReqReady;
  endtask

  // apply the decided events at the clock edge
  task automatic model_commit();
    logic [31:0] popped;
    popped = 32'd0;
    if (e_pop) begin
      popped = oq_addr[0];
      oq_addr.delete(0);
      oq_stale.delete(0);
    end
    if (e_mark_stale) oq_stale[0] = 1'b1;
    if (e_hold_pop) begin
      hq_instr.delete(0);
      hq_pc.delete(0);
    end
    if (e_to_hold) begin
      hq_instr.push_back(ImemRespData);
      hq_pc.push_back(popped);
    end
    if (e_accept) begin
      oq_addr.push_back(m_pcf);
      oq_stale.push_back(Redirect);
    end
    if (FlushD) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!StallF) begin
      if (e_deliver) begin
        m_valid = 1'b1;
        m_instr = e_d_instr;
        m_pcd   = e_d_pc;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
`ifdef FETCH_PERF_CNT_EN
    if (e_deliver) m_fetch_cnt = m_fetch_cnt + 32'd1;
    if (e_discard) m_drop_cnt = m_drop_cnt + 32'd1;
`endif
    if (e_deliver || Redirect) m_pcf = PC_In;
  endtask

  // one clock cycle: drive inputs, predict, step the edge, update model and memory
  task automatic apply_stimulus(input bit rd, input logic [31:0] tgt, input bit st,
                                input bit fl, input bit rdy, input int lat);
    logic [31:0] acc_addr;
    Redirect     = rd;
    PC_In        = rd ? tgt : m_pcf + 32'd4;
    StallF       = st;
    FlushD       = fl;
    ImemReqReady = rdy;
    if (mem_busy && mem_wait == 0) begin
      ImemRespValid = 1'b1;
      ImemRespData  = mem_word(mem_addr);
    end else begin
      ImemRespValid = 1'b0;
      ImemRespData  = $urandom;
    end
    model_eval();
    acc_addr = m_pcf;
    @(posedge CPU_CLK);
    #1;
    model_commit();
    if (ImemRespValid) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (e_accept) begin
      mem_busy = 1'b1;
      mem_wait = lat - 1;
      mem_addr = acc_addr;
    end
  endtask

  // every cycle, away from the rising edge, compare all outputs against the model
  always @(negedge CPU_CLK) begin
    if (check_en) begin
      check_output("PCF", PCF, m_pcf);
      check_output("ImemReqAddr", ImemReqAddr, m_pcf);
      check_output("ImemReqValid", {31'd0, ImemReqValid}, {31'd0, e_req_valid});
      check_output("FetchBusy", {31'd0, FetchBusy}, {31'd0, !e_deliver});
      check_output("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
      check_output("InstrD", InstrD, m_instr);
      if (m_valid) check_output("PCD", PCD, m_pcd);
`ifdef FETCH_PERF_CNT_EN
      check_output("FetchCnt", FetchCnt, m_fetch_cnt);
      check_output("DropCnt", DropCnt, m_drop_cnt);
`endif
    end
  end

  initial begin
    bit prev_rd;
    bit found;
    CPU_RST = 1'b1;
    PC_In = 32'd0; Redirect = 1'b0; StallF = 1'b0; FlushD = 1'b0;
    ImemReqReady = 1'b0; ImemRespValid = 1'b0; ImemRespData = 32'd0;
    model_reset();
    #2;
    check_output("rst_PCF", PCF, RESET_PC);
    check_output("rst_InstrD", InstrD, NOP);
    check_output("rst_PCD", PCD, 32'd0);
    check_output("rst_ValidD", {31'd0, ValidD}, 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST  = 1'b0;
    check_en = 1'b1;
    $display("[TB] reset released");

    // straight-line fetch, always-ready memory with 1-cycle latency
    check_output("seq_addr0", ImemReqAddr, 32'h0);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("seq_pcd0", PCD, 32'h0);
    check_output("seq_valid0", {31'd0, ValidD}, 32'd1);
    check_output("seq_addr4", ImemReqAddr, 32'h4);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("seq_bubble", {31'd0, ValidD}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("seq_pcd4", PCD, 32'h4);
    check_output("seq_addr8", ImemReqAddr, 32'h8);

    // redirect to 0x100 one cycle after the 0x8 request is accepted
    apply_stimulus(0, 0, 0, 0, 1, 2);
    apply_stimulus(1, 32'h100, 0, 0, 1, 1);
    check_output("rd_addr", ImemReqAddr, 32'h100);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("rd_valid", {31'd0, ValidD}, 32'd0);
    check_output("rd_reqvalid", {31'd0, ImemReqValid}, 32'd1);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("rd_pcd", PCD, 32'h100);
    check_output("rd_validd", {31'd0, ValidD}, 32'd1);

    // stall for 3 cycles while the 0x104 response arrives
    apply_stimulus(0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 1, 0, 1, 1);
    apply_stimulus(0, 0, 1, 0, 1, 1);
    apply_stimulus(0, 0, 1, 0, 1, 1);
    check_output("st_pcd_held", PCD, 32'h100);
    check_output("st_pcf_held", PCF, 32'h104);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("st_pcd", PCD, 32'h104);
    check_output("st_instr", InstrD, mem_word(32'h104));
    check_output("st_addr", ImemReqAddr, 32'h108);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("st_once", {31'd0, ValidD}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 1, 1);

    // memory not ready for 4 cycles, redirect to 0x200 in the second
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output("nr_addr_old", ImemReqAddr, 32'h10C);
    apply_stimulus(1, 32'h200, 0, 0, 0, 1);
    check_output("nr_addr_new", ImemReqAddr, 32'h200);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1);
    check_output("nr_pcd", PCD, 32'h200);

    // flush together with a deliver
    apply_stimulus(0, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1, 1, 1);
    check_output("fl_valid", {31'd0, ValidD}, 32'd0);
    check_output("fl_instr", InstrD, 32'h0000_0013);
    check_output("fl_pcf", PCF, 32'h208);

    // randomized traffic
    prev_rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      rd = !prev_rd && ($urandom_range(0, 7) == 0);
      apply_stimulus(rd, 32'($urandom_range(0, 4095)) << 2, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(1, 3)));
      prev_rd = rd;
    end

    // reach a live outstanding request, then reset in the middle of it
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      apply_stimulus(0, 0, 0, 0, 1, 3);
      found = (oq_addr.size() == 1) && !oq_stale[0] && (hq_instr.size() == 0);
    end
    check_output("reach_wait", {31'd0, found}, 32'd1);
    check_en = 1'b0;
    #1;
    CPU_RST = 1'b1;
    #1;
    check_output("mid_rst_PCF", PCF, RESET_PC);
    check_output("mid_rst_InstrD", InstrD, NOP);
    check_output("mid_rst_PCD", PCD, 32'd0);
    check_output("mid_rst_ValidD", {31'd0, ValidD}, 32'd0);
    check_output("mid_rst_ReqValid", {31'd0, ImemReqValid}, 32'd1);
    @(posedge CPU_CLK);
    #1;
    model_reset();
    CPU_RST  = 1'b0;
    check_en = 1'b1;
    check_output("post_rst_addr", ImemReqAddr, RESET_PC);
    prev_rd = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bit rd;
      rd = !prev_rd && ($urandom_range(0, 7) == 0);
      apply_stimulus(rd, 32'($urandom_range(0, 4095)) << 2, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(1, 3)));
      prev_rd = rd;
    end

    check_en = 1'b0;
    @(negedge CPU_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
IF-stage PC register and instruction-fetch controller. It sits directly downstream of the next-PC generator: it consumes `PC_In` and a redirect strobe, and drives `PCF` back to that generator. It issues one request at a time to a variable-latency instruction memory over a valid/ready interface. It delivers the fetched instruction and its PC into the IF/ID register, and supports stall, flush and redirect while a request is in flight.

Parameters:
- `RESET_PC`, default 32'h0000_0000: value loaded into `PCF` on reset.
- `NOP_INSTR`, default 32'h0000_0013: value placed in `InstrD` on reset and on flush.

Ports:
- `CPU_CLK` in 1: clock, rising edge.
- `CPU_RST` in 1: asynchronous, active-high reset.
- `PC_In` in 32: next PC from the NPC generator. Equals `PCF`+4 unless a redirect is active.
- `Redirect` in 1: `PC_In` is a control-flow target (`BranchE` | `JalrE` | `JalD`). Single-cycle pulse.
- `StallF` in 1: hazard unit requests that the IF/ID register hold.
- `FlushD` in 1: hazard unit requests that the IF/ID contents be squashed.
- `PCF` out 32: current fetch PC.
- `ImemReqValid` out 1: fetch request valid.
- `ImemReqAddr` out 32: fetch address; always equals `PCF`.
- `ImemReqReady` in 1: memory accepts the request this cycle.
- `ImemRespValid` in 1: response data valid. Exactly one response per accepted request, arriving at least 1 cycle after acceptance.
- `ImemRespData` in 32: instruction word.
- `InstrD` out 32: IF/ID instruction.
- `PCD` out 32: IF/ID PC.
- `ValidD` out 1: IF/ID holds a real instruction.
- `FetchBusy` out 1: high when no instruction is delivered into IF/ID this cycle.

Behaviour:
- Reset values (async, immediate):
  - `PCF`=`RESET_PC`, `InstrD`=`NOP_INSTR`, `PCD`=0, `ValidD`=0.
  - State=REQ, hold buffer empty.
- FSM states:
  - REQ: `ImemReqValid`=1.
  - WAIT: request accepted, response pending.
  - DROP: stale request outstanding; its response is discarded.
  - HOLD: response captured, waiting for `StallF` to drop.
- REQ transitions:
  - `ImemReqReady` & !`Redirect` → WAIT.
  - `ImemReqReady` & `Redirect` → DROP, `PCF`<=`PC_In`.
  - !`ImemReqReady` & `Redirect` → stay in REQ, `PCF`<=`PC_In`. The request address changes while unaccepted; this is legal only on redirect.
- WAIT transitions, on `ImemRespValid`:
  - If `Redirect`: discard the data, `PCF`<=`PC_In`, → REQ.
  - Else if `StallF`: capture data and `PCF` into the hold buffer, → HOLD.
  - Else deliver: `InstrD`<=data, `PCD`<=`PCF`, `ValidD`<=1, `PCF`<=`PC_In`, → REQ.
- WAIT with no response: `Redirect` → DROP, `PCF`<=`PC_In`.
- DROP transitions:
  - Response arrives → REQ; data discarded; `ValidD` is unaffected by the discarded data.
  - `Redirect` in DROP: `PCF`<=`PC_In`, stay in DROP until the response arrives.
- HOLD transitions:
  - !`StallF` → deliver from the hold buffer, `PCF`<=`PC_In`, → REQ.
  - `Redirect` → empty the buffer, `PCF`<=`PC_In`, → REQ.
- IF/ID update priority per edge, highest first:
  1. `FlushD`: `ValidD`<=0, `InstrD`<=`NOP_INSTR`.
  2. `StallF`: hold all IF/ID contents.
  3. Deliver.
  4. Otherwise bubble: `ValidD`<=0, `InstrD`<=`NOP_INSTR`.
- `FetchBusy` is combinational: 1 unless a deliver occurs this cycle.
- `PCF` changes only on deliver or redirect; it is held otherwise, including under `StallF`.
- Throughput with a 1-cycle-latency, always-ready memory: one instruction every 2 cycles. At most one outstanding request; no other pipelining.
- Reset mid-request: state returns to REQ. The next response from the previously outstanding request is not tracked. The memory must also be reset by `CPU_RST`.

Optional Feature:
Macro `FETCH_PERF_CNT_EN`.
- When defined, two extra outputs exist, both reset to 0 and wrapping at 2^32:
  - `FetchCnt` out 32: increments on each deliver.
  - `DropCnt` out 32: increments on each discarded response, in WAIT-with-redirect or DROP.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
1. Reset release, memory always ready, 1-cycle latency, no redirect:
   - `ImemReqAddr` sequence is 0x0, 0x4, 0x8.
   - `PCD` sequence is 0x0, 0x4, 0x8 with `ValidD`=1 every second cycle.
2. Redirect to 0x100 one cycle after a request to 0x8 is accepted:
   - The 0x8 response is discarded and `ValidD` stays 0.
   - The next request is to 0x100 and `PCD`=0x100 is delivered.
3. `StallF`=1 for 3 cycles while the 0x4 response arrives:
   - IF/ID holds the 0x0 instruction.
   - After `StallF` drops, `PCD`=0x4 is delivered exactly once and the next request is to 0x8.
4. `ImemReqReady`=0 for 4 cycles with `Redirect`=1 to 0x200 in cycle 2:
   - `ImemReqAddr` switches from 0x8 to 0x200 while held.
   - The accepted request is to 0x200.
5. `FlushD` and deliver in the same cycle → `ValidD`=0 and `InstrD`=0x00000013.
6. `CPU_RST` asserted during WAIT → outputs reach their reset values without a clock edge; after release the first request is to `RESET_PC`.
